// File: rtl/syscall_read_responder_pkg.sv
// Shared constants and FSM state type for the syscall read-return path.
package syscall_pkg;

    localparam logic [5:0]  FUNCT_SYSCALL = 6'h0c;
    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_READ_INT  = 32'd5;
    localparam logic [31:0] SYS_EXIT      = 32'd10;
    localparam logic [31:0] SYS_READ_CHAR = 32'd12;
    localparam logic [4:0]  REG_V0        = 5'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_WRITE
    } rd_state_e;

endpackage

// File: rtl/syscall_read_responder_if.sv
// Request, host-FIFO and register-file write signals of the read responder.
interface syscall_read_responder_if #(parameter int CNT_W = 16);

    logic             syscall_control;
    logic [31:0]      instruction;
    logic [31:0]      v0;
    logic             host_valid;
    logic [31:0]      host_data;
    logic             host_ready;
    logic             stall;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic [CNT_W-1:0] reads_served;

    modport slave (
        input  syscall_control, instruction, v0, host_valid, host_data,
        output host_ready, stall, rf_we, rf_waddr, rf_wdata, reads_served
    );

    modport master (
        output syscall_control, instruction, v0, host_valid, host_data,
        input  host_ready, stall, rf_we, rf_waddr, rf_wdata, reads_served
    );

endinterface

// File: rtl/syscall_read_responder_input_fifo.sv
// Synchronous power-of-two FIFO holding host-supplied values for read syscalls.
module syscall_input_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/syscall_read_responder.sv
// Services read_int (and read_char when SYSCALL_READ_CHAR_EN is defined) by
// stalling until host data is queued, then writing it to $v0.
module syscall_read_responder
    import syscall_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    syscall_read_responder_if.slave  bus
);

    rd_state_e          state_q, state_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   served_q, served_d;

    logic               is_syscall, read_int, read_char, req;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0]        fifo_head, ret_value;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign is_syscall = bus.syscall_control && (bus.instruction[5:0] == FUNCT_SYSCALL);
    assign read_int   = (bus.v0 == SYS_READ_INT);
`ifdef SYSCALL_READ_CHAR_EN
    assign read_char  = (bus.v0 == SYS_READ_CHAR);
`else
    assign read_char  = 1'b0;
`endif
    assign req        = is_syscall && (read_int || read_char);

    assign fifo_push  = bus.host_valid && !fifo_full;
    assign fifo_pop   = (state_q == ST_WRITE);

    syscall_input_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.host_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        assert (fifo_empty == (fifo_count == '0));
    end

    assign ret_value = read_char ? {24'b0, fifo_head[7:0]} : fifo_head;

    // Write data is captured on entry to WRITE; the head is stable then since
    // pushes to a non-empty FIFO never move it.
    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        wdata_d  = '0;
        served_d = served_q;
        case (state_q)
            ST_IDLE: begin
                if (req && !fifo_empty) begin
                    state_d = ST_WRITE;
                    we_d    = 1'b1;
                    wdata_d = ret_value;
                end else if (req) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (!fifo_empty) begin
                    state_d = ST_WRITE;
                    we_d    = 1'b1;
                    wdata_d = ret_value;
                end
            end
            ST_WRITE: begin
                state_d  = ST_IDLE;
                served_d = served_q + CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            served_q <= served_d;
        end
    end

    // Gated by rst_n so a request held across reset does not stall.
    assign bus.stall        = rst_n && req && (state_q != ST_WRITE);
    assign bus.host_ready   = !fifo_full;
    assign bus.rf_we        = we_q;
    assign bus.rf_waddr     = REG_V0;
    assign bus.rf_wdata     = wdata_q;
    assign bus.reads_served = served_q;

endmodule

// File: tb/tb_syscall_read_responder.sv
// Directed self-checking bench for syscall_read_responder.
module tb_syscall_read_responder;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [CNT_W-1:0] exp_served = '0;

    syscall_read_responder_if #(.CNT_W(CNT_W)) bus ();

    syscall_read_responder #(
        .FIFO_DEPTH (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] code);
        bus.syscall_control = 1'b1;
        bus.instruction     = 32'h0000_000c;
        bus.v0              = code;
    endtask

    task automatic clear_req();
        bus.syscall_control = 1'b0;
        bus.instruction     = 32'h0;
        bus.v0              = 32'h0;
    endtask

    task automatic push_word(input logic [31:0] d);
        bus.host_valid = 1'b1;
        bus.host_data  = d;
        tick();
        bus.host_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.host_ready !== 1'b1) begin bad++; $display("FAIL reset_host_ready: got %b want 1", bus.host_ready); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we: got %b want 0", bus.rf_we); end
        total++; if (bus.rf_wdata !== 32'h0) begin bad++; $display("FAIL reset_rf_wdata: got %h want 0", bus.rf_wdata); end
        total++; if (bus.rf_waddr !== 5'd2) begin bad++; $display("FAIL reset_rf_waddr: got %0d want 2", bus.rf_waddr); end
        total++; if (bus.reads_served !== 16'd0) begin bad++; $display("FAIL reset_served: got %0d want 0", bus.reads_served); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_read_int();
        push_word(32'd42);
        set_req(32'd5);
        @(negedge clk);
        total++; if (bus.stall !== 1'b1 || bus.rf_we !== 1'b0) begin bad++; $display("FAIL readint_stall: got stall=%b we=%b want 1/0", bus.stall, bus.rf_we); end
        tick();
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b1 || bus.stall !== 1'b0) begin bad++; $display("FAIL readint_write: got we=%b stall=%b want 1/0", bus.rf_we, bus.stall); end
        total++; if (bus.rf_waddr !== 5'd2) begin bad++; $display("FAIL readint_waddr: got %0d want 2", bus.rf_waddr); end
        total++; if (bus.rf_wdata !== 32'd42) begin bad++; $display("FAIL readint_wdata: got %h want %h", bus.rf_wdata, 32'd42); end
        tick();
        clear_req();
        exp_served = 16'd1;
        @(negedge clk);
        total++; if (bus.reads_served !== exp_served || bus.rf_we !== 1'b0) begin bad++; $display("FAIL readint_served: got %0d we=%b want %0d we=0", bus.reads_served, bus.rf_we, exp_served); end
        tick();
    endtask

    task automatic test_wait_empty();
        set_req(32'd5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if (bus.stall !== 1'b1 || bus.rf_we !== 1'b0) begin bad++; $display("FAIL wait_stall%0d: got stall=%b we=%b want 1/0", i, bus.stall, bus.rf_we); end
            tick();
        end
        push_word(32'hDEAD_BEEF);
        @(negedge clk);
        total++; if (bus.stall !== 1'b1 || bus.rf_we !== 1'b0) begin bad++; $display("FAIL wait_no_bypass: got stall=%b we=%b want 1/0", bus.stall, bus.rf_we); end
        tick();
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'hDEAD_BEEF || bus.stall !== 1'b0) begin bad++; $display("FAIL wait_write: got we=%b data=%h stall=%b want 1/deadbeef/0", bus.rf_we, bus.rf_wdata, bus.stall); end
        tick();
        clear_req();
        exp_served = exp_served + 16'd1;
        @(negedge clk);
        total++; if (bus.reads_served !== exp_served) begin bad++; $display("FAIL wait_served: got %0d want %0d", bus.reads_served, exp_served); end
        tick();
    endtask

    task automatic test_full_and_back_to_back();
        logic [31:0] vals [5];
        for (int i = 0; i < 5; i++) vals[i] = 32'h100 + 32'(i);
        bus.host_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.host_data = vals[i];
            tick();
        end
        bus.host_data = vals[4];
        @(negedge clk);
        total++; if (bus.host_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", bus.host_ready); end
        tick();
        set_req(32'd5);
        @(negedge clk);
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL full_stall: got %b want 1", bus.stall); end
        tick();
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== vals[0]) begin bad++; $display("FAIL full_first: got we=%b data=%h want 1/%h", bus.rf_we, bus.rf_wdata, vals[0]); end
        total++; if (bus.host_ready !== 1'b0) begin bad++; $display("FAIL full_ready_in_pop: got %b want 0", bus.host_ready); end
        tick();
        clear_req();
        exp_served = exp_served + 16'd1;
        @(negedge clk);
        total++; if (bus.host_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop: got %b want 1", bus.host_ready); end
        tick();
        bus.host_valid = 1'b0;
        // Request held continuously: each read is stall, write, then re-evaluated.
        for (int i = 1; i < 5; i++) begin
            set_req(32'd5);
            @(negedge clk);
            total++; if (bus.stall !== 1'b1 || bus.rf_we !== 1'b0) begin bad++; $display("FAIL b2b_stall%0d: got stall=%b we=%b want 1/0", i, bus.stall, bus.rf_we); end
            tick();
            @(negedge clk);
            total++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== vals[i]) begin bad++; $display("FAIL b2b_data%0d: got we=%b data=%h want 1/%h", i, bus.rf_we, bus.rf_wdata, vals[i]); end
            tick();
            exp_served = exp_served + 16'd1;
        end
        clear_req();
        @(negedge clk);
        total++; if (bus.reads_served !== exp_served) begin bad++; $display("FAIL b2b_served: got %0d want %0d", bus.reads_served, exp_served); end
        tick();
    endtask

    task automatic test_push_pop();
        push_word(32'hA1);
        set_req(32'd5);
        tick();
        bus.host_valid = 1'b1;
        bus.host_data  = 32'hB2;
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'hA1) begin bad++; $display("FAIL pp_first: got we=%b data=%h want 1/a1", bus.rf_we, bus.rf_wdata); end
        tick();
        bus.host_valid = 1'b0;
        clear_req();
        exp_served = exp_served + 16'd1;
        set_req(32'd5);
        tick();
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'hB2) begin bad++; $display("FAIL pp_second: got we=%b data=%h want 1/b2", bus.rf_we, bus.rf_wdata); end
        tick();
        clear_req();
        exp_served = exp_served + 16'd1;
        @(negedge clk);
        total++; if (bus.reads_served !== exp_served) begin bad++; $display("FAIL pp_served: got %0d want %0d", bus.reads_served, exp_served); end
        tick();
    endtask

    task automatic test_read_char();
        push_word(32'h1234_5641);
        set_req(32'd12);
`ifdef SYSCALL_READ_CHAR_EN
        @(negedge clk);
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL char_stall: got %b want 1", bus.stall); end
        tick();
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'h41) begin bad++; $display("FAIL char_data: got we=%b data=%h want 1/41", bus.rf_we, bus.rf_wdata); end
        tick();
        clear_req();
        exp_served = exp_served + 16'd1;
`else
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.stall !== 1'b0 || bus.rf_we !== 1'b0) begin bad++; $display("FAIL char_ignored%0d: got stall=%b we=%b want 0/0", i, bus.stall, bus.rf_we); end
            tick();
        end
        set_req(32'd5);
        tick();
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'h1234_5641) begin bad++; $display("FAIL char_kept: got we=%b data=%h want 1/12345641", bus.rf_we, bus.rf_wdata); end
        tick();
        clear_req();
        exp_served = exp_served + 16'd1;
`endif
        @(negedge clk);
        total++; if (bus.reads_served !== exp_served) begin bad++; $display("FAIL char_served: got %0d want %0d", bus.reads_served, exp_served); end
        tick();
    endtask

    task automatic test_flush();
        set_req(32'd5);
        tick();
        tick();
        clear_req();
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", bus.stall); end
        tick();
        push_word(32'd7);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL flush_no_write%0d: got %b want 0", i, bus.rf_we); end
            tick();
        end
        set_req(32'd5);
        tick();
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'd7) begin bad++; $display("FAIL flush_later_read: got we=%b data=%h want 1/7", bus.rf_we, bus.rf_wdata); end
        tick();
        clear_req();
        exp_served = exp_served + 16'd1;
        @(negedge clk);
        total++; if (bus.reads_served !== exp_served) begin bad++; $display("FAIL flush_served: got %0d want %0d", bus.reads_served, exp_served); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        set_req(32'd5);
        tick();
        push_word(32'h55);
        rst_n = 1'b0;
        exp_served = '0;
        #1;
        total++; if (bus.stall !== 1'b0 || bus.rf_we !== 1'b0) begin bad++; $display("FAIL rstwait_outputs: got stall=%b we=%b want 0/0", bus.stall, bus.rf_we); end
        total++; if (bus.host_ready !== 1'b1 || bus.reads_served !== exp_served) begin bad++; $display("FAIL rstwait_state: got ready=%b served=%0d want 1/0", bus.host_ready, bus.reads_served); end
        clear_req();
        tick();
        tick();
        rst_n = 1'b1;
        set_req(32'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.stall !== 1'b1 || bus.rf_we !== 1'b0) begin bad++; $display("FAIL rstwait_fifo_empty%0d: got stall=%b we=%b want 1/0", i, bus.stall, bus.rf_we); end
            tick();
        end
        clear_req();
        tick();
    endtask

    task automatic test_reset_mid_write();
        push_word(32'h77);
        set_req(32'd5);
        tick();
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'h77) begin bad++; $display("FAIL rstwrite_pre: got we=%b data=%h want 1/77", bus.rf_we, bus.rf_wdata); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (bus.rf_we !== 1'b0 || bus.rf_wdata !== 32'h0 || bus.stall !== 1'b0) begin bad++; $display("FAIL rstwrite_abort: got we=%b data=%h stall=%b want 0/0/0", bus.rf_we, bus.rf_wdata, bus.stall); end
        clear_req();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.reads_served !== exp_served || bus.rf_we !== 1'b0) begin bad++; $display("FAIL rstwrite_served: got %0d we=%b want %0d/0", bus.reads_served, bus.rf_we, exp_served); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.host_valid = 1'b0;
        bus.host_data  = 32'h0;
        clear_req();
        test_reset();
        test_read_int();
        test_wait_empty();
        test_full_and_back_to_back();
        test_push_pop();
        test_read_char();
        test_flush();
        test_reset_mid_wait();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
